// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler that shares one approximate 8x8 multiplier among NUM_REQ requesters.
// Each request holds the multiplier for one cycle and returns one tagged response.

module unsigned_int_mul (
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic [5:0]  Conf_Bit_Mask,
   output logic [15:0] R
);
   // Mask bit 0 keeps the two top partial-product rows and bit 5 keeps the two
   // bottom rows. Bits 1..4 keep rows 5..2. All ones gives the exact product.
   logic [7:0]  row_en;
   logic [15:0] pp [8];

   assign row_en = {{2{Conf_Bit_Mask[0]}}, Conf_Bit_Mask[1], Conf_Bit_Mask[2],
                    Conf_Bit_Mask[3], Conf_Bit_Mask[4], {2{Conf_Bit_Mask[5]}}};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pp
         assign pp[gi] = (row_en[gi] && B[gi]) ? ({8'b0, A} << gi) : 16'b0;
      end
   endgenerate

   always_comb begin
      R = '0;
      for (int i = 0; i < 8; i++) begin
         R = R + pp[i];
      end
   end
endmodule

module approx_mul_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_A,
   input  logic [NUM_REQ*8-1:0] req_B,
   input  logic [NUM_REQ*6-1:0] req_mask,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_R,
   output logic [5:0]           rsp_mask,
   output logic                 busy,
   output logic [15:0]          mask_fix_cnt
);
   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   state_t          state_reg, state_next;
   logic [ID_W-1:0] ptr_reg;
   logic [7:0]      op_a_reg, op_b_reg;
   logic [5:0]      op_m_reg;
   logic [ID_W-1:0] op_id_reg;
   logic            rsp_valid_reg;
   logic [ID_W-1:0] rsp_id_reg;
   logic [15:0]     rsp_r_reg;
   logic [5:0]      rsp_mask_reg;
   logic [15:0]     fix_cnt_reg;

   logic [2*NUM_REQ-1:0] valid_rot;
   logic                 grant_any;
   logic [ID_W-1:0]      grant_id;
   logic [ID_W-1:0]      ptr_next;
   logic                 accept_en;
   logic [7:0]           sel_a, sel_b;
   logic [5:0]           sel_m, sel_m_fixed;
   logic [15:0]          mul_r;
   int                   sum;

   // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
   always_comb begin
      valid_rot = {req_valid, req_valid} >> ptr_reg;
      grant_any = 1'b0;
      grant_id  = '0;
      sum       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) begin
            grant_any = 1'b1;
            sum       = int'(ptr_reg) + k;
            if (sum >= NUM_REQ) begin
               sum = sum - NUM_REQ;
            end
            grant_id  = ID_W'(sum);
         end
      end
   end

   assign accept_en = !rst && (state_reg == IDLE) && grant_any;
   assign ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = accept_en && (grant_id == ID_W'(gi));
      end
   endgenerate

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      sel_m = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_a = req_A[8*i +: 8];
            sel_b = req_B[8*i +: 8];
            sel_m = req_mask[6*i +: 6];
         end
      end
   end

   // A zero mask would suppress every partial product; promote it to the coarsest legal one.
   assign sel_m_fixed = (sel_m == 6'd0) ? 6'b000001 : sel_m;

   unsigned_int_mul u_mul (
      .A             (op_a_reg),
      .B             (op_b_reg),
      .Conf_Bit_Mask (op_m_reg),
      .R             (mul_r)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = MUL;
         MUL:     state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         op_a_reg      <= '0;
         op_b_reg      <= '0;
         op_m_reg      <= '0;
         op_id_reg     <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_r_reg     <= '0;
         rsp_mask_reg  <= '0;
         fix_cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (grant_any) begin
                  op_a_reg  <= sel_a;
                  op_b_reg  <= sel_b;
                  op_m_reg  <= sel_m_fixed;
                  op_id_reg <= grant_id;
                  ptr_reg   <= ptr_next;
                  if (sel_m == 6'd0 && fix_cnt_reg != 16'hFFFF) begin
                     fix_cnt_reg <= fix_cnt_reg + 16'd1;
                  end
               end
            end
            MUL: begin
               rsp_r_reg     <= mul_r;
               rsp_id_reg    <= op_id_reg;
               rsp_mask_reg  <= op_m_reg;
               rsp_valid_reg <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid    = rsp_valid_reg;
   assign rsp_id       = rsp_id_reg;
   assign rsp_R        = rsp_r_reg;
   assign rsp_mask     = rsp_mask_reg;
   assign busy         = (state_reg != IDLE);
   assign mask_fix_cnt = fix_cnt_reg;
endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Directed and randomized bench for approx_mul_rr_sched: arbitration order, latency,
// backpressure, mask substitution, reset recovery and a scoreboarded random sweep.

module tb_approx_mul_rr_sched;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*8-1:0] req_A;
   logic [NUM_REQ*8-1:0] req_B;
   logic [NUM_REQ*6-1:0] req_mask;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [15:0]          rsp_R;
   logic [5:0]           rsp_mask;
   logic                 busy;
   logic [15:0]          mask_fix_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   approx_mul_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_A        (req_A),
      .req_B        (req_B),
      .req_mask     (req_mask),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_R        (rsp_R),
      .rsp_mask     (rsp_mask),
      .busy         (busy),
      .mask_fix_cnt (mask_fix_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: product of A with only the B bits whose rows the mask keeps.
   function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b, input logic [5:0] m);
      logic [5:0]  mm;
      logic [7:0]  keep;
      logic [15:0] p;
      mm   = (m == 6'd0) ? 6'd1 : m;
      keep = {{2{mm[0]}}, mm[1], mm[2], mm[3], mm[4], {2{mm[5]}}};
      p    = {8'b0, a} * {8'b0, (b & keep)};
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [5:0] m);
      req_A[id*8 +: 8]    = a;
      req_B[id*8 +: 8]    = b;
      req_mask[id*6 +: 6] = m;
   endtask

   // One isolated request with hand-computed expected result and mask.
   task automatic do_txn(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] m, input logic [15:0] exp_r, input logic [5:0] exp_m);
      int n;
      @(negedge clk);
      set_req(id, a, b, m);
      req_valid = NUM_REQ'(1) << id;
      rsp_ready = 1'b1;
      #1;
      n = 0;
      while (req_ready == '0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val({tag, "_ready"}, req_ready, NUM_REQ'(1) << id);
      @(negedge clk);
      req_valid = '0;
      #1;
      check_val({tag, "_mul_novalid"}, rsp_valid, 0);
      check_val({tag, "_busy"}, busy, 1);
      @(negedge clk);
      #1;
      check_val({tag, "_valid"}, rsp_valid, 1);
      check_val({tag, "_id"}, rsp_id, id);
      check_val({tag, "_R"}, rsp_R, exp_r);
      check_val({tag, "_mask"}, rsp_mask, exp_m);
      $display("txn %s id=%0d A=%0d B=%0d mask=%0d -> R=%0d mask=%0d", tag, rsp_id, a, b, m, rsp_R, rsp_mask);
   endtask

   initial begin
      int gid[$];
      int gcyc[$];
      int pend[$];
      int ex_id[$];
      int ex_r[$];
      int ex_m[$];
      logic [15:0] held_r;
      logic [ID_W-1:0] held_id;
      logic pending [NUM_REQ];
      int issued, accepted, responded, cyc, last_acc, idx;

      rst       = 1'b1;
      req_valid = '0;
      req_A     = '0;
      req_B     = '0;
      req_mask  = '0;
      rsp_ready = 1'b0;

      // Reset state and req_ready gating while rst is high
      @(negedge clk);
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      check_val("rst_ready", req_ready, 0);
      check_val("rst_valid", rsp_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_R", rsp_R, 0);
      check_val("rst_id", rsp_id, 0);
      check_val("rst_mask", rsp_mask, 0);
      check_val("rst_cnt", mask_fix_cnt, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // Single request: 200*150 keeping only rows 7..6 -> 200*128
      do_txn("single", 2, 8'd200, 8'd150, 6'b000001, 16'd25600, 6'b000001);

      // Fairness with all requesters continuously valid
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i + 3), 8'(i + 5), 6'h3F);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && gid.size() < 6; c++) begin
         #1;
         if (rsp_valid) begin
            if (pend.size() == 0) check_val("rr_unexpected_rsp", 1, 0);
            else check_val("rr_rsp_id", rsp_id, pend.pop_front());
         end
         if (req_ready != '0) begin
            check_val("rr_onehot", $onehot(req_ready), 1);
            gid.push_back($clog2(req_ready));
            gcyc.push_back(c);
            pend.push_back($clog2(req_ready));
         end
         @(negedge clk);
      end
      req_valid = '0;
      check_val("rr_count", gid.size(), 6);
      for (int k = 0; k < gid.size(); k++) begin
         check_val("rr_order", gid[k], k % NUM_REQ);
         if (k > 0) check_val("rr_spacing", gcyc[k] - gcyc[k-1], 3);
      end
      $display("txn rr grants=%p", gid);
      repeat (3) @(negedge clk);

      // Backpressure: hold the response for 10 cycles
      do_reset();
      @(negedge clk);
      set_req(0, 8'd9, 8'd7, 6'h3F);
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      #1;
      check_val("bp_ready", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = 4'hF;
      @(negedge clk);
      #1;
      check_val("bp_valid", rsp_valid, 1);
      check_val("bp_R", rsp_R, 63);
      check_val("bp_id", rsp_id, 0);
      held_r  = rsp_R;
      held_id = rsp_id;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         check_val("bp_hold_valid", rsp_valid, 1);
         check_val("bp_hold_R", rsp_R, 63);
         check_val("bp_hold_id", rsp_id, 0);
         check_val("bp_hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check_val("bp_next_grant", req_ready, 4'b0010);
      check_val("bp_released", rsp_valid, 0);
      req_valid = '0;
      $display("txn bp id=%0d R=%0d held 10 cycles", held_id, held_r);

      // Mask substitution and other mask patterns
      check_val("m0_cnt_before", mask_fix_cnt, 0);
      do_txn("mask0", 1, 8'd17, 8'd3, 6'd0, 16'd0, 6'b000001);
      check_val("m0_cnt_after", mask_fix_cnt, 1);
      do_txn("exact", 3, 8'd200, 8'd150, 6'h3F, 16'd30000, 6'h3F);
      do_txn("lowrows", 0, 8'd255, 8'd255, 6'h20, 16'd765, 6'h20);
      do_txn("midrows", 2, 8'd13, 8'd255, 6'h1E, 16'd780, 6'h1E);
      check_val("m_cnt_stable", mask_fix_cnt, 1);

      // Reset while in MUL
      @(negedge clk);
      set_req(0, 8'd9, 8'd7, 6'h3F);
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("rmul_busy_pre", busy, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rmul_valid", rsp_valid, 0);
      check_val("rmul_busy", busy, 0);
      check_val("rmul_grant0", req_ready, 4'b0001);

      // Reset while in RESP
      @(negedge clk);
      @(negedge clk);
      #1;
      check_val("rresp_valid_pre", rsp_valid, 1);
      check_val("rresp_R_pre", rsp_R, 63);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rresp_valid", rsp_valid, 0);
      check_val("rresp_busy", busy, 0);
      check_val("rresp_R", rsp_R, 0);
      check_val("rresp_cnt", mask_fix_cnt, 0);
      check_val("rresp_grant0", req_ready, 4'b0001);
      req_valid = '0;

      // Random sweep with scoreboard
      for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
      issued    = 0;
      accepted  = 0;
      responded = 0;
      cyc       = 0;
      last_acc  = -1;
      while (responded < 1000 && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         if (last_acc >= 0) begin
            req_valid[last_acc] = 1'b0;
            last_acc = -1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pending[i] && issued < 1000 && $urandom_range(0, 1) == 1) begin
               set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 6'($urandom_range(1, 63)));
               req_valid[i] = 1'b1;
               pending[i]   = 1'b1;
               issued++;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (req_ready != '0) begin
            if (($onehot(req_ready) != 1'b1) || ((req_ready & ~req_valid) != '0))
               check_val("sw_ready_legal", req_ready, req_valid);
            idx = $clog2(req_ready);
            ex_id.push_back(idx);
            ex_r.push_back(golden(req_A[idx*8 +: 8], req_B[idx*8 +: 8], req_mask[idx*6 +: 6]));
            ex_m.push_back(req_mask[idx*6 +: 6]);
            pending[idx] = 1'b0;
            last_acc     = idx;
            accepted++;
         end
         if (rsp_valid && rsp_ready) begin
            if (ex_id.size() == 0) begin
               check_val("sw_extra_rsp", 1, 0);
            end else begin
               check_val("sw_id", rsp_id, ex_id.pop_front());
               check_val("sw_R", rsp_R, ex_r.pop_front());
               check_val("sw_mask", rsp_mask, ex_m.pop_front());
            end
            responded++;
            $display("txn sweep %0d id=%0d R=%0d mask=%0d", responded, rsp_id, rsp_R, rsp_mask);
         end
      end
      req_valid = '0;
      check_val("sw_accepted", accepted, 1000);
      check_val("sw_responded", responded, 1000);
      check_val("sw_leftover", ex_id.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/approx_mul_rr_sched.md
Name: approx_mul_rr_sched

Overview:
- Round-robin scheduler that shares one internal unsigned_int_mul instance (8x8 -> 16, configurable approximation via Conf_Bit_Mask) among NUM_REQ requesters.
- Each requester supplies operands and its own approximation mask over a valid/ready handshake.
- One result at a time is returned on a tagged valid/ready response port.
- Sits between accelerator clients and the approximate multiplier.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester tag; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_A  in  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i].
- req_B  in  NUM_REQ*8  operand B; same packing as req_A.
- req_mask  in  NUM_REQ*6  per-requester Conf_Bit_Mask; bits [6i+5:6i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_R  out  16  product from unsigned_int_mul.
- rsp_mask  out  6  mask actually applied to the product.
- busy  out  1  high in any state other than IDLE.
- mask_fix_cnt  out  16  count of accepted requests with mask 0; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rsp_valid=0, rsp_id=0, rsp_R=0, rsp_mask=0, ptr=0, mask_fix_cnt=0, internal operand registers=0.
- While rst=1, req_ready=0 combinationally. Reset mid-operation discards the in-flight request without a response.

FSM states and transitions:
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge: latch opA=req_A[g], opB=req_B[g], opM=req_mask[g], opId=g; set ptr=(g+1) mod NUM_REQ; go to MUL.
  - If no req_valid bit is set, stay in IDLE; req_ready=0 and ptr is unchanged.
- MUL:
  - opA, opB and opM drive the multiplier instance.
  - On the edge: rsp_R<=R, rsp_id<=opId, rsp_mask<=opM, rsp_valid<=1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; all response outputs are held stable.
  - On rsp_ready=1: rsp_valid<=0 and go to IDLE. Otherwise stay.
  - req_ready=0 throughout.

Timing and ordering:
- Latency: request accepted at edge N, rsp_valid high from edge N+1 onward.
- Minimum spacing between accepts is 3 cycles (accept, MUL, RESP with rsp_ready=1).
- req_valid dropping while not granted has no effect; there is no request queue.
- Requesters must hold req_valid and their data until req_ready. Data changes before the grant are allowed; only the accept-cycle value is used.

Mask rules:
- Legal masks are 6'b000001..6'b111111.
- A mask of 0 is replaced by 6'b000001 at latch time; mask_fix_cnt increments on that accept.
- rsp_mask reports the substituted value.

Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 grants.

Test Plan:
- Single request: req_valid=4'b0100, A=8'd200, B=8'd150, mask=6'b000001 -> req_ready=4'b0100 for one cycle. rsp_valid is seen 1 cycle later with rsp_id=2 and rsp_mask=6'b000001. rsp_R equals a standalone unsigned_int_mul golden output for the same inputs.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1. Accepts are exactly 3 cycles apart. Each rsp_id matches its grant.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_R and rsp_id stay stable and req_ready stays 0. After rsp_ready=1, the next grant occurs the following cycle.
- Mask 0: requester 1 sends mask=6'd0, A=8'd17, B=8'd3 -> rsp_mask=6'b000001 and mask_fix_cnt goes 0->1. rsp_R equals the golden output for mask 6'b000001.
- Reset in MUL and in RESP: assert rst for 1 cycle -> rsp_valid=0, busy=0, ptr=0 next cycle. The next grant with all valid goes to requester 0.
- Sweep: 1000 random (A, B, mask in 1..63, requester) transactions with random rsp_ready -> every accepted request yields exactly one response. Responses match the golden model; none are lost or duplicated.
